// File: rtl/rv32i_types.sv
// Shared RV32I pipeline types: register-index width and the stage control bus.
// Holds types and constants only, so it has no latency or backpressure behaviour.
package rv32i_types;

    localparam int REG_ADDR_W = 5;

    typedef struct packed {
        logic pc_load;
        logic ifid_load;
        logic idex_load;
        logic exmem_load;
        logic memwb_load;
        logic ifid_flush;
        logic idex_flush;
        logic exmem_flush;
        logic memwb_flush;
    } pipe_ctrl_t;

endpackage

// File: rtl/perf_counter.sv
// Free-running event counter: wraps modulo 2^W and does not saturate.
// Counts one per cycle with inc high; synchronous reset clears it.
module perf_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (inc) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/pipeline_control.sv
// 5-stage pipeline sequencer: freeze on memory wait, load-use bubble, redirect squash.
// Combinational enables (zero latency); a memory not ready holds every stage.
module pipeline_control #(
    parameter int REG_ADDR_W = rv32i_types::REG_ADDR_W,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  icache_resp,
    input  logic                  dmem_active,
    input  logic                  dcache_resp,
    input  logic                  idex_mem_read,
    input  logic [REG_ADDR_W-1:0] idex_rd,
    input  logic [REG_ADDR_W-1:0] ifid_rs1,
    input  logic [REG_ADDR_W-1:0] ifid_rs2,
    input  logic                  ifid_uses_rs2,
    input  logic                  redirect,
    output logic                  icache_read,
    output logic                  dcache_req,
    output logic                  ifetch_hold,
    output logic                  pc_load,
    output logic                  ifid_load,
    output logic                  idex_load,
    output logic                  exmem_load,
    output logic                  memwb_load,
    output logic                  ifid_flush,
    output logic                  idex_flush,
    output logic                  exmem_flush,
    output logic                  memwb_flush,
    output logic [CNT_W-1:0]      stall_count,
    output logic [CNT_W-1:0]      flush_count
);

    rv32i_types::pipe_ctrl_t ctrl;

    logic i_done;
    logic d_done;
    logic i_ok;
    logic d_ok;
    logic advance;
    logic load_use;

    assign i_ok    = icache_resp | i_done;
    assign d_ok    = ~dmem_active | dcache_resp | d_done;
    assign advance = i_ok & d_ok;

    assign load_use = idex_mem_read && (idex_rd != '0) &&
                      ((idex_rd == ifid_rs1) || (ifid_uses_rs2 && (idex_rd == ifid_rs2)));

    // Sticky completion flags let the two ports finish in different cycles.
    always_ff @(posedge clk) begin
        if (reset || advance) begin
            i_done <= 1'b0;
            d_done <= 1'b0;
        end else begin
            i_done <= i_done | icache_resp;
            d_done <= d_done | (dcache_resp & dmem_active);
        end
    end

    always_comb begin
        ctrl        = '0;
        icache_read = 1'b0;
        dcache_req  = 1'b0;
        ifetch_hold = 1'b0;
        if (reset) begin
            ctrl.ifid_flush  = 1'b1;
            ctrl.idex_flush  = 1'b1;
            ctrl.exmem_flush = 1'b1;
            ctrl.memwb_flush = 1'b1;
        end else begin
            icache_read = ~i_done;
            dcache_req  = dmem_active & ~d_done;
            ifetch_hold = icache_resp & ~advance;
            if (advance) begin
                // Redirect wins: the dependent instruction is squashed anyway.
                if (redirect) begin
                    ctrl.pc_load    = 1'b1;
                    ctrl.ifid_load  = 1'b1;
                    ctrl.idex_load  = 1'b1;
                    ctrl.exmem_load = 1'b1;
                    ctrl.memwb_load = 1'b1;
                    ctrl.ifid_flush = 1'b1;
                    ctrl.idex_flush = 1'b1;
                end else if (load_use) begin
                    ctrl.idex_load  = 1'b1;
                    ctrl.idex_flush = 1'b1;
                    ctrl.exmem_load = 1'b1;
                    ctrl.memwb_load = 1'b1;
                end else begin
                    ctrl.pc_load    = 1'b1;
                    ctrl.ifid_load  = 1'b1;
                    ctrl.idex_load  = 1'b1;
                    ctrl.exmem_load = 1'b1;
                    ctrl.memwb_load = 1'b1;
                end
            end
        end
    end

    assign pc_load     = ctrl.pc_load;
    assign ifid_load   = ctrl.ifid_load;
    assign idex_load   = ctrl.idex_load;
    assign exmem_load  = ctrl.exmem_load;
    assign memwb_load  = ctrl.memwb_load;
    assign ifid_flush  = ctrl.ifid_flush;
    assign idex_flush  = ctrl.idex_flush;
    assign exmem_flush = ctrl.exmem_flush;
    assign memwb_flush = ctrl.memwb_flush;

    perf_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (~advance),
        .count (stall_count)
    );

    perf_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (advance & redirect),
        .count (flush_count)
    );

endmodule

// File: tb/tb_pipeline_control.sv
// Directed bench for pipeline_control: a driver queues hand-computed expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_pipeline_control;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        icache_resp = 1'b0;
    logic        dmem_active = 1'b0;
    logic        dcache_resp = 1'b0;
    logic        idex_mem_read = 1'b0;
    logic [4:0]  idex_rd = '0;
    logic [4:0]  ifid_rs1 = '0;
    logic [4:0]  ifid_rs2 = '0;
    logic        ifid_uses_rs2 = 1'b0;
    logic        redirect = 1'b0;
    logic        icache_read, dcache_req, ifetch_hold;
    logic        pc_load, ifid_load, idex_load, exmem_load, memwb_load;
    logic        ifid_flush, idex_flush, exmem_flush, memwb_flush;
    logic [31:0] stall_count, flush_count;

    pipeline_control #(.REG_ADDR_W(5), .CNT_W(32)) dut (
        .clk           (clk),
        .reset         (reset),
        .icache_resp   (icache_resp),
        .dmem_active   (dmem_active),
        .dcache_resp   (dcache_resp),
        .idex_mem_read (idex_mem_read),
        .idex_rd       (idex_rd),
        .ifid_rs1      (ifid_rs1),
        .ifid_rs2      (ifid_rs2),
        .ifid_uses_rs2 (ifid_uses_rs2),
        .redirect      (redirect),
        .icache_read   (icache_read),
        .dcache_req    (dcache_req),
        .ifetch_hold   (ifetch_hold),
        .pc_load       (pc_load),
        .ifid_load     (ifid_load),
        .idex_load     (idex_load),
        .exmem_load    (exmem_load),
        .memwb_load    (memwb_load),
        .ifid_flush    (ifid_flush),
        .idex_flush    (idex_flush),
        .exmem_flush   (exmem_flush),
        .memwb_flush   (memwb_flush),
        .stall_count   (stall_count),
        .flush_count   (flush_count)
    );

    always #5 clk = ~clk;

    // {loads[4:0] pc..memwb, flushes[3:0] ifid..memwb, icache_read, dcache_req, ifetch_hold, stall, flush}
    typedef logic [75:0] obs_t;

    localparam logic [4:0] L_ALL = 5'b11111;
    localparam logic [4:0] L_NO  = 5'b00000;
    localparam logic [4:0] L_LU  = 5'b00111;
    localparam logic [3:0] F_RST = 4'b1111;
    localparam logic [3:0] F_NO  = 4'b0000;
    localparam logic [3:0] F_RD  = 4'b1100;
    localparam logic [3:0] F_BUB = 4'b0100;

    obs_t  exp_q[$];
    string name_q[$];
    int    applied = 0;
    int    miscompares = 0;
    bit    stim_done = 1'b0;

    task automatic step(input string nm,
                        input bit rst, input bit icr, input bit dma, input bit dcr,
                        input bit mr, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input bit u2, input bit rdir,
                        input logic [4:0] ld, input logic [3:0] fl,
                        input bit ir, input bit dq, input bit hd,
                        input int sc, input int fc);
        @(posedge clk);
        #1;
        reset         = rst;
        icache_resp   = icr;
        dmem_active   = dma;
        dcache_resp   = dcr;
        idex_mem_read = mr;
        idex_rd       = rd;
        ifid_rs1      = rs1;
        ifid_rs2      = rs2;
        ifid_uses_rs2 = u2;
        redirect      = rdir;
        exp_q.push_back({ld, fl, ir, dq, hd, 32'(sc), 32'(fc)});
        name_q.push_back(nm);
    endtask

    // Monitor: every cycle is an output cycle for this combinational controller.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            obs_t  act;
            obs_t  exp_v;
            string nm;
            act = {pc_load, ifid_load, idex_load, exmem_load, memwb_load,
                   ifid_flush, idex_flush, exmem_flush, memwb_flush,
                   icache_read, dcache_req, ifetch_hold, stall_count, flush_count};
            exp_v = exp_q.pop_front();
            nm    = name_q.pop_front();
            applied++;
            if (act !== exp_v) begin
                miscompares++;
                $display("FAIL %s: got ld=%b fl=%b ir/dq/hd=%b stall=%0d flush=%0d, want ld=%b fl=%b ir/dq/hd=%b stall=%0d flush=%0d",
                         nm, act[75:71], act[70:67], act[66:64], act[63:32], act[31:0],
                         exp_v[75:71], exp_v[70:67], exp_v[66:64], exp_v[63:32], exp_v[31:0]);
            end
        end
    end

    initial begin
        // Reset with instruction responses present: they must be ignored.
        for (int i = 0; i < 3; i++)
            step("reset", 1,1,0,0, 0,0,0,0,0,0, L_NO, F_RST, 0,0,0, 0,0);
        step("run0", 0,1,0,0, 0,0,0,0,0,0, L_ALL, F_NO, 1,0,0, 0,0);
        step("run1", 0,1,0,0, 0,0,0,0,0,0, L_ALL, F_NO, 1,0,0, 0,0);

        // icache answers in cycle 1, dcache in cycle 4.
        step("mem_c1", 0,1,1,0, 0,0,0,0,0,0, L_NO,  F_NO, 1,1,1, 0,0);
        step("mem_c2", 0,0,1,0, 0,0,0,0,0,0, L_NO,  F_NO, 0,1,0, 1,0);
        step("mem_c3", 0,0,1,0, 0,0,0,0,0,0, L_NO,  F_NO, 0,1,0, 2,0);
        step("mem_c4", 0,0,1,1, 0,0,0,0,0,0, L_ALL, F_NO, 0,1,0, 3,0);
        step("mem_c5", 0,1,0,0, 0,0,0,0,0,0, L_ALL, F_NO, 1,0,0, 3,0);

        // Load-use via rs1, then rd=0, then via rs2 with and without uses_rs2.
        step("lu_rs1",   0,1,0,0, 1,5,5,0,0,0, L_LU,  F_BUB, 1,0,0, 3,0);
        step("lu_after", 0,1,0,0, 0,5,5,0,0,0, L_ALL, F_NO,  1,0,0, 3,0);
        step("lu_x0",    0,1,0,0, 1,0,0,0,0,0, L_ALL, F_NO,  1,0,0, 3,0);
        step("lu_rs2",   0,1,0,0, 1,7,1,7,1,0, L_LU,  F_BUB, 1,0,0, 3,0);
        step("lu_rs2_n", 0,1,0,0, 1,7,1,7,0,0, L_ALL, F_NO,  1,0,0, 3,0);

        // Redirect beats load-use.
        step("rd_lu",    0,1,0,0, 1,5,5,0,0,1, L_ALL, F_RD, 1,0,0, 3,0);
        step("rd_after", 0,1,0,0, 0,0,0,0,0,0, L_ALL, F_NO, 1,0,0, 3,1);

        // Redirect held through a two-cycle data stall.
        step("rdst_a", 0,1,1,0, 0,0,0,0,0,1, L_NO,  F_NO, 1,1,1, 3,1);
        step("rdst_b", 0,0,1,0, 0,0,0,0,0,1, L_NO,  F_NO, 0,1,0, 4,1);
        step("rdst_c", 0,0,1,1, 0,0,0,0,0,1, L_ALL, F_RD, 0,1,0, 5,1);
        step("rdst_d", 0,1,0,0, 0,0,0,0,0,0, L_ALL, F_NO, 1,0,0, 5,2);

        // Set d_done, pulse reset, then the data port must be re-requested.
        step("dd_set", 0,0,1,1, 0,0,0,0,0,0, L_NO,  F_RST & 4'b0000, 1,1,0, 5,2);
        step("dd_rst", 1,1,1,1, 0,0,0,0,0,0, L_NO,  F_RST, 0,0,0, 6,2);
        step("dd_req", 0,1,1,0, 0,0,0,0,0,0, L_NO,  F_NO,  1,1,1, 0,0);
        step("dd_adv", 0,0,1,1, 0,0,0,0,0,0, L_ALL, F_NO,  0,1,0, 1,0);
        step("dd_end", 0,1,0,0, 0,0,0,0,0,0, L_ALL, F_NO,  1,0,0, 1,0);
        stim_done = 1'b1;
    end

    initial begin
        int budget;
        budget = 0;
        while (!(stim_done && exp_q.size() == 0) && budget < 2000) begin
            @(posedge clk);
            budget++;
        end
        @(posedge clk);
        if (exp_q.size() != 0 || !stim_done) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
